ex_muldiv_unit: RTL
===================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width; legal values are even integers from 8 to 64.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 valid_i  input  1  SHALL indicate a request is present on op_i, operand_a_i, operand_b_i and rd_addr_i.
REQ-005 op_i  input  3  SHALL carry the RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_a_i  input  XLEN  SHALL be the forwarded rs1 value.
REQ-007 operand_b_i  input  XLEN  SHALL be the forwarded rs2 value.
REQ-008 rd_addr_i  input  5  SHALL be the destination register tag.
REQ-009 flush_i  input  1  SHALL be the pipeline kill request.
REQ-010 result_ready_i  input  1  SHALL indicate that EX/MEM accepts the result.
REQ-011 ready_o  output  1  SHALL indicate that a request can be accepted.
REQ-012 busy_o  output  1  SHALL be the stall request to the hazard unit.
REQ-013 result_valid_o  output  1  SHALL indicate that result_o and rd_addr_o are valid.
REQ-014 result_o  output  XLEN  SHALL carry the operation result.
REQ-015 rd_addr_o  output  5  SHALL carry the destination tag of the completed operation.

Function
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 ready_o SHALL be 1 only in IDLE.
REQ-018 busy_o SHALL be 1 in CALC, and in DONE while result_ready_i=0.
REQ-019 result_valid_o SHALL be 1 only in DONE.
REQ-020 Accept SHALL occur on a rising edge with valid_i=1, ready_o=1 and flush_i=0; accept latches the operands, op_i and rd_addr_i.
REQ-021 On accept, the FSM SHALL go to CALC and clear the iteration counter.
REQ-022 On accept of a fast-path case (REQ-025, REQ-026), the FSM SHALL go directly to DONE.
REQ-023 Multiplication SHALL be iterative shift-add, one bit per cycle, over XLEN iterations on operand magnitudes.
- Sign rules: MUL and MULH use both operands signed; MULHSU uses a signed, b unsigned; MULHU uses both unsigned.
- The 2*XLEN product SHALL be negated when exactly one signed operand is negative.
- MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
REQ-024 Division SHALL be iterative restoring, one quotient bit per cycle, over XLEN iterations on magnitudes.
- The quotient SHALL be negated when the operand signs differ (DIV).
- The remainder SHALL take the sign of the dividend (REM).
REQ-025 Divide by zero SHALL take the fast path, with results:
- DIV and DIVU: all ones.
- REM and REMU: operand_a.
REQ-026 Signed overflow (a = most-negative value, b = -1, DIV/REM) SHALL take the fast path, with results:
- DIV: operand_a.
- REM: 0.
REQ-027 CALC SHALL last exactly XLEN cycles, then the FSM goes to DONE.
- result_valid_o rises XLEN+1 cycles after the accept edge.
- On the fast path, result_valid_o rises 1 cycle after the accept edge.
REQ-028 In DONE, result_o and rd_addr_o SHALL stay stable until result_ready_i=1; on that edge the FSM returns to IDLE.
- A new accept SHALL be possible on the following edge at the earliest.
REQ-029 flush_i=1 SHALL force IDLE on the next edge from any state and discard the operation; flush wins over a simultaneous accept or result handshake.
REQ-030 In IDLE, changes on the inputs SHALL NOT alter the outputs.

Reset
REQ-031 While rst_n=0, the unit SHALL hold IDLE with ready_o=1, busy_o=0, result_valid_o=0, result_o=0, rd_addr_o=0, and the counter and internal registers cleared.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately; no result is produced after release.

Verification
REQ-033 With XLEN=32, a bench SHALL cover at least the following scenarios:
- MUL a=7, b=0xFFFFFFFD -> result_o=0xFFFFFFEB; result_valid_o rises 33 cycles after accept.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU with the same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=0 -> 0xFFFFFFFF and REMU with the same operands -> 100, both 1 cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both take the fast path.
- flush_i pulsed in CALC cycle 10 -> IDLE next edge, no result_valid_o; a following DIVU 9/3 -> 3 with rd_addr_o matching.
- result_ready_i held 0 for 5 cycles in DONE -> result_o stable, busy_o=1; rst_n pulsed low mid-CALC -> all outputs at reset values, no result after release.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide execution unit.
//   Multiply: shift-add over operand magnitudes, one bit per cycle.
//   Divide:   restoring division over magnitudes, one quotient bit per cycle.
//   Divide-by-zero and signed overflow skip the iteration and finish at once.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i, op_i     request strobe, RV M-extension funct3
//   operand_a_i/b_i   rs1 / rs2 values (XLEN bits)
//   rd_addr_i         destination register tag
//   flush_i           pipeline kill, wins over accept and result handshake
//   result_ready_i    downstream accepts the result
//   ready_o           unit is idle and can take a request
//   busy_o            stall request to the hazard unit
//   result_valid_o    result_o / rd_addr_o hold a completed operation
//   result_o          operation result
//   rd_addr_o         destination tag of the completed operation
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  input  logic            result_ready_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg_q;   // negate product / quotient at the end
  logic              r_neg_r;   // negate remainder at the end
  // Shared datapath registers:
  //   multiply: r_acc = partial product, r_x = shifted multiplicand, r_y = multiplier
  //   divide:   r_acc[XLEN-1:0] = partial remainder, r_x[XLEN-1:0] = divisor,
  //             r_y = dividend bits shifting out / quotient bits shifting in
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_x;
  logic [XLEN-1:0]   r_y;
  logic [XLEN-1:0]   r_result;

  // Request decode
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  // Iteration
  logic              w_last;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_x_nxt;
  logic [XLEN-1:0]   w_y_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_accept   = valid_i && (r_state == S_IDLE) && !flush_i;

  assign w_a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                      (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                      (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_a_neg    = w_a_signed && operand_a_i[XLEN-1];
  assign w_b_neg    = w_b_signed && operand_b_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? -operand_a_i : operand_a_i;
  assign w_b_mag    = w_b_neg ? -operand_b_i : operand_b_i;

  assign w_div_zero = op_i[2] && (operand_b_i == '0);
  assign w_ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (operand_b_i == '1);
  assign w_fast     = w_div_zero || w_ovf;

  // op_i[1] separates the REM variants from the DIV variants.
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = op_i[1] ? operand_a_i : '1;
    else if (w_ovf)
      w_fast_res = op_i[1] ? '0 : operand_a_i;
  end

  assign w_last  = (r_cnt == CW'(XLEN-1));
  assign w_trial = {r_acc[XLEN-1:0], r_y[XLEN-1]} - {1'b0, r_x[XLEN-1:0]};

  always_comb begin
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_op[2]) begin
      // Restoring step: keep the trial difference only if it did not borrow.
      if (!w_trial[XLEN])
        w_acc_nxt = {{XLEN{1'b0}}, w_trial[XLEN-1:0]};
      else
        w_acc_nxt = {{XLEN{1'b0}}, r_acc[XLEN-2:0], r_y[XLEN-1]};
      w_y_nxt = {r_y[XLEN-2:0], !w_trial[XLEN]};
    end else begin
      if (r_y[0])
        w_acc_nxt = r_acc + r_x;
      w_x_nxt = r_x << 1;
      w_y_nxt = r_y >> 1;
    end
  end

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg_q ? -w_y_nxt : w_y_nxt;
  assign w_rem  = r_neg_r ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                        w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_final = w_quo;
      OP_REM, OP_REMU:               w_final = w_rem;
      default:                       w_final = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    w_state_nxt    = r_state;
    ready_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept)
          w_state_nxt = w_fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (flush_i)
          w_state_nxt = S_IDLE;
        else if (w_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        result_valid_o = 1'b1;
        busy_o         = !result_ready_i;
        if (flush_i || result_ready_i)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= op_i;
      r_rd    <= rd_addr_i;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_acc   <= '0;
      // Multiply shifts a and consumes b; divide shifts the dividend a through r_y.
      r_x     <= {{XLEN{1'b0}}, op_i[2] ? w_b_mag : w_a_mag};
      r_y     <= op_i[2] ? w_a_mag : w_b_mag;
      if (w_fast)
        r_result <= w_fast_res;
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      if (w_last)
        r_result <= w_final;
    end
  end

  assign result_o  = r_result;
  assign rd_addr_o = r_rd;

endmodule
